// File: rtl/mem_arbiter_ctrl.sv
// Two-state arbiter that grants one cache port at a time to the shared L2 port.
// Policy: fixed priority by default, round robin when ARB_ROUND_ROBIN_EN is defined.
module mem_arbiter_ctrl #(
  parameter int NUM_PORTS = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PORTS-1:0]         pmem_read,
  input  logic [NUM_PORTS-1:0]         pmem_write,
  input  logic                         l2_resp,
  output logic [NUM_PORTS-1:0]         service,
  output logic [$clog2(NUM_PORTS)-1:0] grant_idx,
  output logic [NUM_PORTS-1:0]         resp,
  output logic                         l2_read,
  output logic                         l2_write,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } state_t;

  state_t               state_reg, state_next;
  logic [NUM_PORTS-1:0] service_reg, service_next;
  logic [IDX_W-1:0]     grant_idx_reg, grant_idx_next;
  logic [NUM_PORTS-1:0] req_vec;
  logic                 win_valid;
  logic [IDX_W-1:0]     win_idx;
  logic                 grant_fire;
  logic                 done_fire;

  assign req_vec = pmem_read | pmem_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic             hi_valid, lo_valid;
  logic [IDX_W-1:0] hi_idx, lo_idx;

  // Lowest requester above the pointer wins; otherwise wrap to the lowest at or below it.
  always_comb begin
    hi_valid = 1'b0;
    lo_valid = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_vec[i]) begin
        if (IDX_W'(i) > rr_ptr_reg) begin
          hi_valid = 1'b1;
          hi_idx   = IDX_W'(i);
        end else begin
          lo_valid = 1'b1;
          lo_idx   = IDX_W'(i);
        end
      end
    end
    win_valid = hi_valid | lo_valid;
    win_idx   = hi_valid ? hi_idx : lo_idx;
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_fire) begin
      rr_ptr_next = win_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg <= IDX_W'(NUM_PORTS - 1);
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end
`else
  // Port 0 (data cache) always has the highest priority.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_vec[i]) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      service_reg   <= '0;
      grant_idx_reg <= '0;
    end else begin
      state_reg     <= state_next;
      service_reg   <= service_next;
      grant_idx_reg <= grant_idx_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    service_next   = service_reg;
    grant_idx_next = grant_idx_reg;
    grant_fire     = 1'b0;
    done_fire      = 1'b0;
    busy           = 1'b0;
    l2_read        = 1'b0;
    l2_write       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (win_valid) begin
          state_next     = SERVICE;
          service_next   = NUM_PORTS'(1) << win_idx;
          grant_idx_next = win_idx;
          grant_fire     = 1'b1;
        end
      end
      SERVICE: begin
        busy     = 1'b1;
        l2_read  = pmem_read[grant_idx_reg];
        l2_write = pmem_write[grant_idx_reg];
        if (l2_resp) begin
          done_fire      = 1'b1;
          state_next     = IDLE;
          service_next   = '0;
          grant_idx_next = '0;
        end
      end
      default: begin
        state_next     = IDLE;
        service_next   = '0;
        grant_idx_next = '0;
      end
    endcase
  end

  assign service   = service_reg;
  assign grant_idx = grant_idx_reg;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_resp
      assign resp[gi] = done_fire & service_reg[gi];
    end
  endgenerate

  generate
    if (TIMEOUT == 0) begin : g_wd_off
      assign timeout_err = 1'b0;
    end else begin : g_wd_on
      localparam int WD_W = $clog2(TIMEOUT + 1);

      logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;
      logic            timeout_reg, timeout_next;

      // Flag rises on the same edge the counter lands on TIMEOUT.
      always_comb begin
        wd_cnt_next  = wd_cnt_reg;
        timeout_next = timeout_reg;
        if (grant_fire) begin
          wd_cnt_next = '0;
        end else if (state_reg == SERVICE && !l2_resp &&
                     wd_cnt_reg != WD_W'(TIMEOUT)) begin
          wd_cnt_next = wd_cnt_reg + WD_W'(1);
        end
        if (wd_cnt_next == WD_W'(TIMEOUT)) begin
          timeout_next = 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wd_cnt_reg  <= '0;
          timeout_reg <= 1'b0;
        end else begin
          wd_cnt_reg  <= wd_cnt_next;
          timeout_reg <= timeout_next;
        end
      end

      assign timeout_err = timeout_reg;
    end
  endgenerate

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Self-checking bench for mem_arbiter_ctrl: directed scenarios then random traffic,
// compared each cycle against a transaction-level model (policy follows ARB_ROUND_ROBIN_EN).
module tb_mem_arbiter_ctrl;

  localparam int NP = 4;
  localparam int TO = 6;
  localparam int IW = $clog2(NP);

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] pmem_read;
  logic [NP-1:0] pmem_write;
  logic          l2_resp;
  logic [NP-1:0] service;
  logic [IW-1:0] grant_idx;
  logic [NP-1:0] resp;
  logic          l2_read;
  logic          l2_write;
  logic          busy;
  logic          timeout_err;

  int errors = 0;
  int checks = 0;

  // Reference model: transaction in flight, owner, SERVICE cycles without response.
  bit            m_busy;
  int            m_gidx;
  int            m_cnt;
  int            m_last;
  bit            m_terr;
  logic [NP-1:0] last_resp;

  always #5 clk = ~clk;

  mem_arbiter_ctrl #(
    .NUM_PORTS(NP),
    .TIMEOUT  (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .l2_resp    (l2_resp),
    .service    (service),
    .grant_idx  (grant_idx),
    .resp       (resp),
    .l2_read    (l2_read),
    .l2_write   (l2_write),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy    = 1'b0;
    m_gidx    = 0;
    m_cnt     = 0;
    m_terr    = 1'b0;
    m_last    = NP - 1;
    last_resp = '0;
  endtask

  function automatic int pick(input logic [NP-1:0] req);
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= NP; k++) begin
      int p;
      p = (m_last + k) % NP;
      if (req[p]) return p;
    end
`else
    for (int p = 0; p < NP; p++) begin
      if (req[p]) return p;
    end
`endif
    return -1;
  endfunction

  task automatic check_outputs();
    logic [NP-1:0] oh;
    oh = m_busy ? (NP'(1) << m_gidx) : '0;
    chk("service",     32'(service),     32'(oh));
    chk("grant_idx",   32'(grant_idx),   m_busy ? m_gidx : 0);
    chk("resp",        32'(resp),        (m_busy && l2_resp) ? 32'(oh) : 32'd0);
    chk("l2_read",     32'(l2_read),     32'(|(pmem_read & oh)));
    chk("l2_write",    32'(l2_write),    32'(|(pmem_write & oh)));
    chk("busy",        32'(busy),        32'(m_busy));
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
  endtask

  task automatic model_advance();
    int w;
    last_resp = '0;
    if (!m_busy) begin
      w = pick(pmem_read | pmem_write);
      if (w >= 0) begin
        m_busy = 1'b1;
        m_gidx = w;
        m_cnt  = 0;
        m_last = w;
      end
    end else if (l2_resp) begin
      last_resp = NP'(1) << m_gidx;
      m_busy    = 1'b0;
    end else begin
      if (m_cnt < TO) m_cnt++;
      if (m_cnt >= TO) m_terr = 1'b1;
    end
  endtask

  task automatic step(input logic [NP-1:0] rd, input logic [NP-1:0] wr, input logic lr);
    @(negedge clk);
    pmem_read  = rd;
    pmem_write = wr;
    l2_resp    = lr;
    #1;
    check_outputs();
    model_advance();
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    pmem_read  = '0;
    pmem_write = '0;
    l2_resp    = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
  endtask

  initial begin
    int            rr_exp[5];
    logic [NP-1:0] rd_r;
    logic [NP-1:0] wr_r;
`ifdef ARB_ROUND_ROBIN_EN
    rr_exp = '{0, 1, 2, 3, 0};
`else
    rr_exp = '{0, 0, 0, 0, 0};
`endif
    rst        = 1'b1;
    pmem_read  = '0;
    pmem_write = '0;
    l2_resp    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // Single read on port 0, response on the third SERVICE cycle.
    step(4'b0001, 4'b0000, 1'b0);
    step(4'b0001, 4'b0000, 1'b0);
    step(4'b0001, 4'b0000, 1'b0);
    step(4'b0001, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b0);
    #1;
    chk("idle_after_resp", 32'(busy), 32'd0);

    // All ports write continuously with l2_resp held: grant order and idle gap.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(4'b0000, 4'b1111, 1'b1);
      #1;
      if (i % 2 == 0) begin
        chk("order_busy", 32'(busy), 32'd1);
        chk("order_idx",  32'(grant_idx), rr_exp[i / 2]);
      end else begin
        chk("order_gap", 32'(busy), 32'd0);
      end
    end
    step(4'b0000, 4'b0000, 1'b0);

    // Watchdog: read on port 1 left unanswered past TIMEOUT, then answered.
    do_reset();
    step(4'b0010, 4'b0000, 1'b0);
    for (int k = 1; k <= TO + 2; k++) begin
      step(4'b0010, 4'b0000, 1'b0);
      #1;
      chk("wd_flag", 32'(timeout_err), (k >= TO) ? 32'd1 : 32'd0);
    end
    step(4'b0010, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b0);
    #1;
    chk("wd_sticky", 32'(timeout_err), 32'd1);

    // Asynchronous reset mid-SERVICE while l2_resp is high.
    step(4'b0100, 4'b0000, 1'b0);
    step(4'b0100, 4'b0000, 1'b0);
    @(negedge clk);
    l2_resp = 1'b1;
    #1;
    check_outputs();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_resp", 32'(resp), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wd",   32'(timeout_err), 32'd0);
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
    step(4'b0100, 4'b0000, 1'b0);
    step(4'b0100, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b0);

    // Random traffic: each request held until its own response, then dropped.
    rd_r = '0;
    wr_r = '0;
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (last_resp[p]) begin
          rd_r[p] = 1'b0;
          wr_r[p] = 1'b0;
        end else if (!rd_r[p] && !wr_r[p] && $urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 2))
            0:       rd_r[p] = 1'b1;
            1:       wr_r[p] = 1'b1;
            default: begin
              rd_r[p] = 1'b1;
              wr_r[p] = 1'b1;
            end
          endcase
        end
      end
      step(rd_r, wr_r, $urandom_range(0, 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
